// File: rtl/tmds_pkg.sv
`default_nettype none
// ============================================================================
// Module  : tmds_pkg
// Brief   : TMDS control tokens, link FSM states and token-to-ctrl mapping.
// Revision: 1.0  initial release
// ============================================================================
package tmds_pkg;

  localparam logic [9:0] c_token_00 = 10'b1101010100;
  localparam logic [9:0] c_token_01 = 10'b0010101011;
  localparam logic [9:0] c_token_10 = 10'b0101010100;
  localparam logic [9:0] c_token_11 = 10'b1010101011;

  typedef enum logic [0:0] {
    SEARCH = 1'b0,
    LOCKED = 1'b1
  } tmds_state_e;

  function automatic logic tmds_is_token(input logic [9:0] sym);
    return (sym == c_token_00) || (sym == c_token_01) ||
           (sym == c_token_10) || (sym == c_token_11);
  endfunction

  // Non-token symbols map to 2'b00; callers qualify with tmds_is_token.
  function automatic logic [1:0] tmds_token_ctrl(input logic [9:0] sym);
    logic [1:0] ctrl;
    ctrl = 2'b00;
    case (sym)
      c_token_01: ctrl = 2'b01;
      c_token_10: ctrl = 2'b10;
      c_token_11: ctrl = 2'b11;
      default:    ctrl = 2'b00;
    endcase
    return ctrl;
  endfunction

endpackage
`default_nettype wire

// File: rtl/tmds_channel_decoder_if.sv
`default_nettype none
// ============================================================================
// Module  : tmds_channel_decoder_if
// Brief   : Raw word input and decoded pixel/control outputs of one channel.
// Revision: 1.0  initial release
// ============================================================================
interface tmds_channel_decoder_if;

  logic [9:0] in_word;
  logic [7:0] out_data;
  logic [1:0] out_ctrl;
  logic       out_de;
  logic       out_locked;
  logic [3:0] out_offset;

  // master: deserializer / consumer side; slave: the decoder itself
  modport master (
    output in_word,
    input  out_data, out_ctrl, out_de, out_locked, out_offset
  );

  modport slave (
    input  in_word,
    output out_data, out_ctrl, out_de, out_locked, out_offset
  );

endinterface
`default_nettype wire

// File: rtl/tmds_symbol_decode.sv
`default_nettype none
// ============================================================================
// Module  : tmds_symbol_decode
// Brief   : Combinational 10b symbol decode into token flag, ctrl and data.
// Revision: 1.0  initial release
// ============================================================================
module tmds_symbol_decode
  import tmds_pkg::*;
(
  input  logic [9:0] window,
  output logic       is_token,
  output logic [1:0] ctrl,
  output logic [7:0] data
);

  logic [7:0] w_q;

  // bit 9 undoes the DC-balance inversion, bit 8 selects XOR vs XNOR chain
  always_comb begin
    w_q     = window[9] ? ~window[7:0] : window[7:0];
    data    = '0;
    data[0] = w_q[0];
    for (int i = 1; i < 8; i++) begin
      data[i] = w_q[i] ^ w_q[i-1] ^ ~window[8];
    end
  end

  assign is_token = tmds_is_token(window);
  assign ctrl     = tmds_token_ctrl(window);

endmodule
`default_nettype wire

// File: rtl/tmds_channel_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tmds_channel_decoder
// Brief   : TMDS channel word aligner (bit-slip search/lock) and 10b decoder.
// Revision: 1.0  initial release
// ============================================================================
module tmds_channel_decoder
  import tmds_pkg::*;
#(
  parameter int c_lock_count     = 16,
  parameter int c_search_timeout = 8192,
  parameter int c_timer_bits     = 14
) (
  input  logic                 clk_pixel,
  input  logic                 rst_n,
  tmds_channel_decoder_if.slave bus
);

  localparam int                     c_run_bits     = $clog2(c_lock_count + 1);
  localparam logic [c_run_bits-1:0]  c_run_target   = c_run_bits'(c_lock_count);
  localparam logic [c_timer_bits-1:0] c_timer_target = c_timer_bits'(c_search_timeout);
  localparam logic [3:0]             c_last_offset  = 4'd9;

  tmds_state_e             state_q, state_d;
  logic [9:0]              prev_word_q, prev_word_d;
  logic [9:0]              window_q, window_d;
  logic [c_run_bits-1:0]   run_q, run_d, w_run_inc;
  logic [c_timer_bits-1:0] timer_q, timer_d, w_timer_inc;
  logic [3:0]              offset_q, offset_d;
  logic [7:0]              data_q, data_d;
  logic [1:0]              ctrl_q, ctrl_d;
  logic                    de_q, de_d;
  logic                    locked_q, locked_d;

  logic [19:0]             w_cat;
  logic                    dec_is_token;
  logic [1:0]              dec_ctrl;
  logic [7:0]              dec_data;

  assign prev_word_d = bus.in_word;
  assign w_cat       = {bus.in_word, prev_word_q};

  // offset 0 selects prev_word exactly; larger offsets pull in early bits of in_word
  always_comb begin
    window_d = w_cat[9:0];
    for (int i = 1; i < 10; i++) begin
      if (offset_q == 4'(i)) begin
        window_d = w_cat[i +: 10];
      end
    end
  end

  tmds_symbol_decode u_symbol_decode (
    .window   (window_q),
    .is_token (dec_is_token),
    .ctrl     (dec_ctrl),
    .data     (dec_data)
  );

  assign w_run_inc   = run_q + c_run_bits'(1);
  assign w_timer_inc = timer_q + c_timer_bits'(1);

  always_comb begin
    state_d  = state_q;
    run_d    = run_q;
    timer_d  = timer_q;
    offset_d = offset_q;
    case (state_q)
      SEARCH: begin
        run_d   = dec_is_token ? w_run_inc : '0;
        timer_d = w_timer_inc;
        // a completed token run wins over a coincident timeout
        if (dec_is_token && (w_run_inc == c_run_target)) begin
          state_d = LOCKED;
          run_d   = '0;
          timer_d = '0;
        end else if (w_timer_inc == c_timer_target) begin
          offset_d = (offset_q == c_last_offset) ? 4'd0 : offset_q + 4'd1;
          run_d    = '0;
          timer_d  = '0;
        end
      end
      LOCKED: begin
        if (dec_is_token) begin
          timer_d = '0;
        end else if (w_timer_inc == c_timer_target) begin
          state_d = SEARCH;
          run_d   = '0;
          timer_d = '0;
        end else begin
          timer_d = w_timer_inc;
        end
      end
      default: begin
        state_d = SEARCH;
      end
    endcase
  end

  // outputs follow the next state so the lock-completing token is already qualified
  always_comb begin
    locked_d = (state_d == LOCKED);
    de_d     = 1'b0;
    data_d   = '0;
    ctrl_d   = '0;
    if (state_d == LOCKED) begin
      if (dec_is_token) begin
        ctrl_d = dec_ctrl;
      end else begin
        ctrl_d = ctrl_q;
        de_d   = 1'b1;
        data_d = dec_data;
      end
    end
  end

  always_ff @(posedge clk_pixel or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SEARCH;
      prev_word_q <= '0;
      window_q    <= '0;
      run_q       <= '0;
      timer_q     <= '0;
      offset_q    <= '0;
      data_q      <= '0;
      ctrl_q      <= '0;
      de_q        <= 1'b0;
      locked_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      prev_word_q <= prev_word_d;
      window_q    <= window_d;
      run_q       <= run_d;
      timer_q     <= timer_d;
      offset_q    <= offset_d;
      data_q      <= data_d;
      ctrl_q      <= ctrl_d;
      de_q        <= de_d;
      locked_q    <= locked_d;
    end
  end

  assign bus.out_data   = data_q;
  assign bus.out_ctrl   = ctrl_q;
  assign bus.out_de     = de_q;
  assign bus.out_locked = locked_q;
  assign bus.out_offset = offset_q;

endmodule
`default_nettype wire

// File: tb/tb_tmds_channel_decoder.sv
`default_nettype none
// ============================================================================
// Module  : tb_tmds_channel_decoder
// Brief   : Scoreboard bench for the TMDS channel decoder (shortened timeout).
// Revision: 1.0  initial release
// ============================================================================
module tb_tmds_channel_decoder;

  localparam int c_timeout = 256;

  logic clk_pixel = 1'b0;
  logic rst_n     = 1'b1;

  tmds_channel_decoder_if bus ();

  tmds_channel_decoder #(
    .c_lock_count     (16),
    .c_search_timeout (c_timeout),
    .c_timer_bits     (14)
  ) dut (
    .clk_pixel (clk_pixel),
    .rst_n     (rst_n),
    .bus       (bus)
  );

  always #5 clk_pixel = ~clk_pixel;

  typedef struct {
    int         due;
    logic       de;
    logic [1:0] ctrl;
    logic [7:0] data;
    int         lock_chk;   // 0 don't care, 1 expect unlocked, 2 expect locked
    int         off_chk;    // -1 don't care
  } exp_t;

  exp_t       sb_q[$];
  int         cyc      = 0;
  int         n_pass   = 0;
  int         n_total  = 0;
  int         shift_t  = 0;
  int         rel_cyc  = 0;
  logic [9:0] prev_sym = '0;
  logic [1:0] last_ctrl = '0;
  logic [3:0] last_off = '0;
  int         off_hist[$];
  int         off_cyc[$];

  always @(posedge clk_pixel) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, got, exp, cyc);
  endtask

  function automatic logic [9:0] tok_sym(input logic [1:0] c);
    logic [9:0] s;
    case (c)
      2'b00:   s = 10'b1101010100;
      2'b01:   s = 10'b0010101011;
      2'b10:   s = 10'b0101010100;
      default: s = 10'b1010101011;
    endcase
    return s;
  endfunction

  function automatic logic is_tok_word(input logic [9:0] w);
    return (w == 10'b1101010100) || (w == 10'b0010101011) ||
           (w == 10'b0101010100) || (w == 10'b1010101011);
  endfunction

  // transmit-side encoder: transition-minimising chain plus optional inversion
  function automatic logic [9:0] tmds_encode(input logic [7:0] d, input logic use_xnor, input logic inv);
    logic [8:0] qm;
    qm[0] = d[0];
    for (int i = 1; i < 8; i++) qm[i] = use_xnor ? ~(qm[i-1] ^ d[i]) : (qm[i-1] ^ d[i]);
    qm[8] = ~use_xnor;
    return {inv, qm[8], inv ? ~qm[7:0] : qm[7:0]};
  endfunction

  // drive one symbol at bit offset shift_t and queue its decoded expectation
  task automatic send_sym(input logic [9:0] sym, input logic is_tok, input logic [1:0] ctl,
                          input logic [7:0] dat, input int lock_chk, input int off_chk);
    logic [19:0] pair;
    exp_t        e;
    @(posedge clk_pixel);
    #1;
    pair        = {sym, prev_sym};
    bus.in_word = (shift_t == 0) ? sym : 10'(pair >> (10 - shift_t));
    prev_sym    = sym;
    if (is_tok) last_ctrl = ctl;
    e.due      = cyc + 3;
    e.de       = !is_tok;
    e.ctrl     = is_tok ? ctl : last_ctrl;
    e.data     = is_tok ? 8'h00 : dat;
    e.lock_chk = lock_chk;
    e.off_chk  = off_chk;
    sb_q.push_back(e);
  endtask

  task automatic send_tok(input logic [1:0] c, input int lock_chk, input int off_chk);
    send_sym(tok_sym(c), 1'b1, c, 8'h00, lock_chk, off_chk);
  endtask

  task automatic send_data(input logic [7:0] b, input int lock_chk, input int off_chk);
    logic [9:0] w;
    int         r;
    r = int'($urandom_range(0, 3));
    w = '0;
    for (int m = 0; m < 4; m++) begin
      w = tmds_encode(b, m[0] ^ r[0], m[1] ^ r[1]);
      if (!is_tok_word(w)) break;
    end
    send_sym(w, 1'b0, 2'b00, b, lock_chk, off_chk);
  endtask

  task automatic release_reset();
    repeat (2) @(negedge clk_pixel);
    rst_n     = 1'b1;
    rel_cyc   = cyc;
    prev_sym  = '0;
    last_ctrl = '0;
    last_off  = '0;
    sb_q.delete();
    off_hist.delete();
    off_cyc.delete();
  endtask

  task automatic do_reset();
    @(negedge clk_pixel);
    rst_n       = 1'b0;
    bus.in_word = '0;
    release_reset();
  endtask

  // output monitor: pops the expectation due this cycle and tracks offset moves
  initial begin
    forever begin
      exp_t e;
      bit   have;
      @(negedge clk_pixel);
      have = 1'b0;
      if (rst_n) begin
        while (sb_q.size() > 0 && sb_q[0].due < cyc) void'(sb_q.pop_front());
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
          e    = sb_q.pop_front();
          have = 1'b1;
        end
        if (bus.out_offset != last_off) begin
          off_hist.push_back(int'(bus.out_offset));
          off_cyc.push_back(cyc);
          last_off = bus.out_offset;
        end
        if (have) begin
          if (e.lock_chk != 0) check("lock_state", bus.out_locked, e.lock_chk == 2);
          if (e.off_chk >= 0)  check("offset", bus.out_offset, e.off_chk);
          if (bus.out_locked)
            check("locked_out", {bus.out_de, bus.out_ctrl, bus.out_data}, {e.de, e.ctrl, e.data});
          else
            check("search_out", {bus.out_de, bus.out_ctrl, bus.out_data}, 11'h000);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, %0d/%0d checks passed", n_pass, n_total);
    $fatal(1, "watchdog");
  end

  initial begin
    int lock_s;
    bus.in_word = '0;

    // reset state, applied asynchronously before any clock edge
    #1 rst_n = 1'b0;
    #2;
    check("rst_data",   bus.out_data,   8'h00);
    check("rst_ctrl",   bus.out_ctrl,   2'b00);
    check("rst_de",     bus.out_de,     1'b0);
    check("rst_locked", bus.out_locked, 1'b0);
    check("rst_offset", bus.out_offset, 4'd0);
    release_reset();

    // aligned stream at offset 0
    for (int i = 1; i <= 20; i++) send_tok(2'b00, (i == 15) ? 1 : (i == 16) ? 2 : 0, -1);
    send_sym(10'b0100000000, 1'b0, 2'b00, 8'h00, 2, 0);
    for (int i = 0; i < 8; i++) send_data(8'($urandom), 2, -1);
    send_tok(2'b01, 0, -1);
    send_data(8'h3C, 0, -1);
    send_tok(2'b10, 0, -1);
    send_tok(2'b11, 0, -1);
    for (int i = 0; i < 4; i++) send_data(8'($urandom), 2, 0);

    // loss of lock after exactly c_timeout data windows
    send_tok(2'b11, 2, -1);
    for (int j = 1; j <= c_timeout; j++)
      send_data(8'($urandom), (j == c_timeout - 1) ? 2 : (j == c_timeout) ? 1 : 0,
                (j == c_timeout) ? 0 : -1);

    // 16th token lands on the timeout cycle: lock must win, offset must hold
    do_reset();
    for (int i = 0; i < c_timeout - 19; i++) send_sym(10'b0100000000, 1'b0, 2'b00, 8'h00, 1, -1);
    for (int i = 1; i <= 16; i++) send_tok(2'b00, (i == 15) ? 1 : (i == 16) ? 2 : 0, (i == 16) ? 0 : -1);
    for (int i = 0; i < 4; i++) send_data(8'($urandom), 2, 0);

    // stream misaligned by 3 bits: offset searches 0,1,2,3 then locks
    do_reset();
    shift_t = 3;
    lock_s  = -1;
    for (int s = 0; s < 1500; s++) begin
      if ((s % 300) < 100) send_tok(2'b01, 0, -1);
      else                 send_data(8'($urandom), 0, -1);
      if (bus.out_locked && lock_s < 0) lock_s = s;
      if (lock_s >= 0 && s >= lock_s + 250) break;
    end
    check("mis_locked", bus.out_locked, 1'b1);
    check("mis_offset", bus.out_offset, 4'd3);
    check("mis_nslips", off_hist.size(), 3);
    if (off_hist.size() == 3) begin
      for (int i = 0; i < 3; i++) begin
        check("mis_step", off_hist[i], i + 1);
        check("mis_slip_cyc", off_cyc[i] - rel_cyc, (i + 1) * c_timeout);
      end
    end

    // asynchronous reset between clock edges while locked at offset 3
    @(posedge clk_pixel);
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_locked", bus.out_locked, 1'b0);
    check("arst_de",     bus.out_de,     1'b0);
    check("arst_ctrl",   bus.out_ctrl,   2'b00);
    check("arst_data",   bus.out_data,   8'h00);
    check("arst_offset", bus.out_offset, 4'd0);
    bus.in_word = '0;
    release_reset();
    shift_t = 0;
    for (int i = 1; i <= 20; i++) send_tok(2'b10, (i == 15) ? 1 : (i == 16) ? 2 : 0, (i == 16) ? 0 : -1);
    for (int i = 0; i < 4; i++) send_data(8'($urandom), 2, 0);

    // wrap-around: nine noise timeouts reach offset 9, tenth wraps to 0
    do_reset();
    for (int i = 0; i < 9 * c_timeout; i++) send_sym(10'($urandom), 1'b0, 2'b00, 8'h00, 1, -1);
    for (int i = 0; i < 600; i++) begin
      send_tok(2'b11, 0, -1);
      if (bus.out_locked) break;
    end
    for (int i = 0; i < 4; i++) send_data(8'($urandom), 2, 0);
    repeat (4) @(negedge clk_pixel);
    check("wrap_locked", bus.out_locked, 1'b1);
    check("wrap_offset", bus.out_offset, 4'd0);
    check("wrap_nslips", off_hist.size(), 10);
    if (off_hist.size() == 10) begin
      for (int i = 0; i < 10; i++) check("wrap_step", off_hist[i], (i + 1) % 10);
      check("wrap_slip_cyc", off_cyc[9] - off_cyc[8], c_timeout);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
